// File: rtl/ex_muldiv_if.sv
// Handshake between the ID/EX pipeline register and the iterative RV32M multiply/divide unit.
// The master side presents the op and operands; the slave side stalls and returns the result.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] opr_1;
  logic [XLEN-1:0] opr_2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output valid, kill, op, opr_1, opr_2,
    input  busy, done, result
  );

  modport slave (
    input  valid, kill, op, opr_1, opr_2,
    output busy, done, result
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// then sign correction. Division by zero and signed overflow finish at accept.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              sign_1;
  logic              sign_2;
  logic [XLEN-1:0]   opd;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     count;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // Accept-time decode of the incoming op.
  logic            signed_1, signed_2, neg_1, neg_2;
  logic [XLEN-1:0] mag_1, mag_2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    signed_1 = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    signed_2 = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    neg_1    = signed_1 & bus.opr_1[XLEN-1];
    neg_2    = signed_2 & bus.opr_2[XLEN-1];
    mag_1    = neg_1 ? -bus.opr_1 : bus.opr_1;
    mag_2    = neg_2 ? -bus.opr_2 : bus.opr_2;
    div_zero = bus.op[2] && (bus.opr_2 == '0);
    div_ovf  = bus.op[2] && !bus.op[0] && (bus.opr_1 == MIN_INT) && (bus.opr_2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.op[1] ? bus.opr_1 : '1;
    else          special_res = bus.op[1] ? '0 : MIN_INT;
  end

  // One iteration step. Multiply keeps {product_hi, multiplier} and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN:0]     sum, shifted, diff;

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it holding its old value and no latch is inferred.
  always_comb begin
    acc_next = acc;
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    shifted  = acc[2*XLEN-1:XLEN-1];
    diff     = shifted - {1'b0, opd};
    if (!op_q[2]) begin
      acc_next = {sum, acc[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction of the final step's value.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fixed;

  always_comb begin
    prod = (sign_1 ^ sign_2) ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    if (!op_q[2])     fixed = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (!op_q[1]) fixed = (sign_1 ^ sign_2) ? -quo : quo;
    else              fixed = sign_1 ? -rem : rem;
  end

  assign bus.busy   = (state == CALC) || ((state == IDLE) && bus.valid && !bus.kill);
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // NOTE: state uses non-blocking assignments so every register samples the values
  // from before the edge; the datapath registers are reset too, so a reset leaves
  // no stale operand or partial result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      sign_1   <= 1'b0;
      sign_2   <= 1'b0;
      opd      <= '0;
      acc      <= '0;
      count    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid && !bus.kill) begin
            op_q   <= bus.op;
            sign_1 <= neg_1;
            sign_2 <= neg_2;
            opd    <= bus.op[2] ? mag_2 : mag_1;
            acc    <= {{XLEN{1'b0}}, (bus.op[2] ? mag_1 : mag_2)};
            count  <= '0;
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.kill) begin
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (count == CW'(XLEN - 1)) begin
              result_q <= fixed;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
        end
        // The instruction still sits in ID/EX here, so valid is not looked at.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: an arithmetic reference model checked every
// cycle, plus directed vectors with literal results and latencies.
module tb_ex_muldiv;
  localparam int XLEN = 32;
  localparam int LAT_CALC = 33;
  localparam int LAT_SPECIAL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(XLEN)) bus ();

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Cycle-level model: cycles left until the result, a done flag, the visible result.
  int          m_wait   = 0;
  bit          m_done   = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_exp    = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait   <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_wait > 0) begin
      if (bus.kill) begin
        m_wait <= 0;
      end else begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_done   <= 1'b1;
          m_result <= m_exp;
        end
      end
    end else if (bus.valid && !bus.kill) begin
      if (is_special(bus.op, bus.opr_1, bus.opr_2)) begin
        m_result <= ref_result(bus.op, bus.opr_1, bus.opr_2);
        m_done   <= 1'b1;
      end else begin
        m_wait <= XLEN;
        m_exp  <= ref_result(bus.op, bus.opr_1, bus.opr_2);
      end
    end
  end

  wire m_busy = (m_wait > 0) || (!m_done && bus.valid && !bus.kill);

  always @(negedge clk) begin
    check("busy", {31'b0, bus.busy}, {31'b0, m_busy});
    check("done", {31'b0, bus.done}, {31'b0, m_done});
    check("result", bus.result, m_result);
    if (bus.done) n_done++;
  end

  // Called at posedge+1 with the unit idle; returns at posedge+1 after the DONE cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit keep);
    int lat = 0;
    int busy_cnt = 0;
    bit got = 1'b0;
    bus.op    = op;
    bus.opr_1 = a;
    bus.opr_2 = b;
    bus.valid = 1'b1;
    @(posedge clk);
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.done) got = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
    check({name, " done seen"}, {31'b0, got}, 32'd1);
    check({name, " result"}, bus.result, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    @(posedge clk);
    #1;
    if (!keep) bus.valid = 1'b0;
  endtask

  initial begin
    int done_before;
    bit done_seen;
    bus.valid = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = '0;
    bus.opr_1 = '0;
    bus.opr_2 = '0;
    #12;
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("MUL 7*-3", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_CALC, 1'b0);
    run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_CALC, 1'b0);
    run_op("MULHU min*min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_CALC, 1'b0);
    run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_CALC, 1'b0);
    run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_CALC, 1'b0);
    run_op("MULHU 2^16*2^16", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, LAT_CALC, 1'b0);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_CALC, 1'b0);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_CALC, 1'b0);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, LAT_CALC, 1'b0);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, LAT_CALC, 1'b0);
    run_op("DIV 100/-7", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_CALC, 1'b0);
    run_op("REM -100/7", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT_CALC, 1'b0);
    run_op("REMU max/16", 3'd7, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, LAT_CALC, 1'b0);
    run_op("DIVU x/0", 3'd5, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, LAT_SPECIAL, 1'b0);
    run_op("REM 5/0", 3'd6, 32'd5, 32'h0, 32'd5, LAT_SPECIAL, 1'b0);
    run_op("DIV min/-1", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL, 1'b0);
    run_op("REM min/-1", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_SPECIAL, 1'b0);
    run_op("DIVU 77/11", 3'd5, 32'd77, 32'd11, 32'd7, LAT_CALC, 1'b0);

    // Flush at CALC step 10: no done, result keeps the previous value.
    bus.op    = 3'd0;
    bus.opr_1 = 32'h0000_1111;
    bus.opr_2 = 32'h0000_2222;
    bus.valid = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.kill  = 1'b1;
    @(posedge clk);
    #1;
    bus.kill  = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    check("kill no done", {31'b0, done_seen}, 32'd0);
    check("kill result held", bus.result, 32'd7);
    check("kill idle busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    run_op("after kill MUL", 3'd0, 32'd1000, 32'd1000, 32'd1000000, LAT_CALC, 1'b0);

    // Asynchronous reset in the middle of CALC, between clock edges.
    bus.op    = 3'd3;
    bus.opr_1 = 32'hFFFF_FFFF;
    bus.opr_2 = 32'hFFFF_FFFF;
    bus.valid = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    bus.valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid reset busy", {31'b0, bus.busy}, 32'd0);
    check("mid reset done", {31'b0, bus.done}, 32'd0);
    check("mid reset result", bus.result, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // valid held across DONE: each op must be accepted exactly once.
    done_before = n_done;
    run_op("b2b MUL", 3'd0, 32'd12, 32'd12, 32'd144, LAT_CALC, 1'b1);
    run_op("b2b DIVU", 3'd5, 32'd144, 32'd12, 32'd12, LAT_CALC, 1'b0);
    repeat (40) @(negedge clk);
    check("b2b done pulses", 32'(n_done - done_before), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
